// File: rtl/mmio_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mmio_uart_tx
//  Purpose  : Memory-mapped 8N1 UART transmitter with a small TX FIFO.
//             Registers: 0 TXDATA (W), 1 STATUS (R), 2 BAUDDIV (R/W), 3 rsvd.
//  Options  : `define UART_TX_PARITY_EN adds an even-parity bit (11-bit frame)
//             and reports the option in STATUS[4].
//  Revision : 1.0 - initial release
// ============================================================================
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  input  logic        mem_ren,
  input  logic        mem_wen,
  output logic [31:0] data_out,
  output logic        tx,
  output logic        tx_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP   = 3'd3
  } state_t;

  // Bus decode
  logic       sel;
  logic [1:0] idx;
  logic       push_req, push, ovf_evt, status_rd, baud_wr;
  assign sel       = (addr[31:4] == BASE_ADDR[31:4]);
  assign idx       = addr[3:2];
  assign push_req  = sel && mem_wen && (idx == 2'd0);
  assign status_rd = sel && mem_ren && (idx == 2'd1);
  assign baud_wr   = sel && mem_wen && (idx == 2'd2);

  // Upper data bits and byte-lane address bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{data_in[31:16], addr[1:0]};

  // FIFO storage and pointers (extra MSB is the wrap bit)
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr, fcount;
  logic        full, empty, pop;
  logic [7:0]  head;
  assign fcount  = wptr - rptr;
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign head    = mem[rptr[AW-1:0]];
  // Full is judged before the edge, so a same-cycle pop never rescues a push.
  assign push    = push_req && !full;
  assign ovf_evt = push_req && full;

  // Control / status registers
  logic [15:0] baud;
  logic        ovf;
  logic [31:0] status, rdata;
  state_t      state_q, state_d;
  assign tx_busy = !empty || (state_q != IDLE);
  assign status  = {19'd0, 5'(fcount), 3'd0, PAR_EN, ovf, tx_busy, empty, full};

  // Serialiser registers
  logic [15:0] div_q, div_d, cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic        par_q, par_d, tx_q, tx_d;
  logic        bit_end;
  assign bit_end = (cnt_q == div_q);
  assign tx      = tx_q;

  // FIFO data array write (no reset needed; pointers qualify contents)
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= data_in[7:0];
  end

  // FIFO pointer update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + {{AW{1'b0}}, 1'b1};
      if (pop)  rptr <= rptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Read mux: values sampled before any same-edge write
  always_comb begin
    rdata = '0;
    if (sel && mem_ren) begin
      case (idx)
        2'd1:    rdata = status;
        2'd2:    rdata = {16'd0, baud};
        default: rdata = '0;
      endcase
    end
  end

  // Register file, sticky overflow and registered read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud     <= DEFAULT_DIV;
      ovf      <= 1'b0;
      data_out <= '0;
    end else begin
      data_out <= rdata;
      if (baud_wr) baud <= data_in[15:0];
      if (ovf_evt)        ovf <= 1'b1;
      else if (status_rd) ovf <= 1'b0;
    end
  end

  // Serialiser state register; tx is driven from the registered next value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  // Serialiser next-state: each bit lasts div_q+1 clocks
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    par_d   = par_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          sh_d    = head;
          par_d   = ^head;
          div_d   = baud;
          cnt_d   = '0;
          bit_d   = '0;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = DATA;
          tx_d    = sh_q[0];
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = par_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            sh_d  = sh_q >> 1;
            tx_d  = sh_q[1];
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = STOP;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = IDLE;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire
